// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package reg_file_mp_pkg;

   typedef enum logic {
      StIdle  = 1'b0,
      StClear = 1'b1
   } rf_state_e;

   function automatic int unsigned rf_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/reg_file_mp_clear_seq.sv
// IDLE/CLEAR sequencer: walks a pointer over every entry, emitting one clear write per cycle.
module reg_file_mp_clear_seq
   import reg_file_mp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   rf_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StClear;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // A request arriving mid-sweep is ignored; the pointer only restarts from idle.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (clear_req) begin
               state_d   = StClear;
               clr_ptr_d = '0;
            end
         end
         StClear: begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (&clr_ptr_q) state_d = StIdle;
         end
         default: state_d = StClear;
      endcase
   end

   always_comb begin
      busy     = (state_q == StClear);
      clr_we   = busy && !reset;
      clr_addr = clr_ptr_q;
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: N combinational read ports, two prioritised write ports,
// optional hardwired zero entry and write-to-read bypass, with a sequential clear sweep.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_RD     = 2,
   parameter bit          ZERO_REG   = 1'b1,
   parameter bit          BYPASS     = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear_req,
   input  logic                         wr0_en,
   input  logic [ADDR_WIDTH-1:0]        wr0_addr,
   input  logic [DATA_WIDTH-1:0]        wr0_data,
   input  logic                         wr1_en,
   input  logic [ADDR_WIDTH-1:0]        wr1_addr,
   input  logic [DATA_WIDTH-1:0]        wr1_data,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic                         busy,
   output logic                         wr_dropped
);

   localparam int unsigned DEPTH = rf_depth(ADDR_WIDTH);

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  wr_ok, we0, we1, drop_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   reg_file_mp_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clk       (clk),
      .reset     (reset),
      .clear_req (clear_req),
      .busy      (busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   // we0/we1 are the writes that actually land; port 0 yields to port 1 on a shared address.
   always_comb begin
      wr_ok  = !reset && !busy && !clear_req;
      we1    = wr1_en && wr_ok && !(ZERO_REG && (wr1_addr == '0));
      we0    = wr0_en && wr_ok && !(ZERO_REG && (wr0_addr == '0)) &&
               !(we1 && (wr0_addr == wr1_addr));
      drop_d = (wr0_en || wr1_en) && !reset && (busy || clear_req);
   end

   always_ff @(posedge clk) begin
      if (clr_we) mem_q[clr_addr] <= '0;
      if (we0)    mem_q[wr0_addr] <= wr0_data;
      if (we1)    mem_q[wr1_addr] <= wr1_data;
   end

   always_ff @(posedge clk) begin
      if (reset) wr_dropped <= 1'b0;
      else       wr_dropped <= drop_d;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;

      always_comb begin
         addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         if (busy)                                 data = '0;
         else if (ZERO_REG && (addr == '0))        data = '0;
         else if (BYPASS && we1 && addr == wr1_addr) data = wr1_data;
         else if (BYPASS && we0 && addr == wr0_addr) data = wr0_data;
         else                                      data = mem_q[addr];
      end

      assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two configurations driven in lockstep against an array-based model.
module tb_reg_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int D  = 32;
   localparam int NR = 2;

   logic              clk = 1'b0;
   logic              reset, clear_req;
   logic              wr0_en, wr1_en;
   logic [AW-1:0]     wr0_addr, wr1_addr;
   logic [DW-1:0]     wr0_data, wr1_data;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data_a, rd_data_b;
   logic              busy_a, busy_b, drop_a, drop_b;

   always #5 clk = ~clk;

   // a: ZERO_REG=1, BYPASS=0   b: ZERO_REG=0, BYPASS=1
   reg_file_mp #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_RD (NR), .ZERO_REG (1'b1), .BYPASS (1'b0)
   ) dut_a (
      .clk (clk), .reset (reset), .clear_req (clear_req),
      .wr0_en (wr0_en), .wr0_addr (wr0_addr), .wr0_data (wr0_data),
      .wr1_en (wr1_en), .wr1_addr (wr1_addr), .wr1_data (wr1_data),
      .rd_addr (rd_addr), .rd_data (rd_data_a), .busy (busy_a), .wr_dropped (drop_a)
   );

   reg_file_mp #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_RD (NR), .ZERO_REG (1'b0), .BYPASS (1'b1)
   ) dut_b (
      .clk (clk), .reset (reset), .clear_req (clear_req),
      .wr0_en (wr0_en), .wr0_addr (wr0_addr), .wr0_data (wr0_data),
      .wr1_en (wr1_en), .wr1_addr (wr1_addr), .wr1_data (wr1_data),
      .rd_addr (rd_addr), .rd_data (rd_data_b), .busy (busy_b), .wr_dropped (drop_b)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          sweep = -1;      // next entry the model sweep clears; -1 when idle
   bit          drop_m = 1'b0;
   bit          synced = 1'b0;
   logic [DW-1:0] mem_m [2][D];
   logic [DW-1:0] obs_rd_a [NR];
   logic [DW-1:0] obs_rd_b [NR];
   logic          obs_busy, obs_drop;

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input int c, input logic [AW-1:0] a);
      bit zr  = (c == 0);
      bit byp = (c == 1);
      if (sweep >= 0) return '0;
      if (zr && a == 0) return '0;
      if (byp && !reset && !clear_req) begin
         if (wr1_en && a == wr1_addr) return wr1_data;
         if (wr0_en && a == wr0_addr) return wr0_data;
      end
      return mem_m[c][a];
   endfunction

   task automatic model_edge();
      if (reset) begin
         sweep  = 0;
         drop_m = 1'b0;
      end else if (sweep >= 0) begin
         drop_m = wr0_en || wr1_en;
         for (int c = 0; c < 2; c++) mem_m[c][sweep] = '0;
         sweep = (sweep == D - 1) ? -1 : sweep + 1;
      end else if (clear_req) begin
         drop_m = wr0_en || wr1_en;
         sweep  = 0;
      end else begin
         drop_m = 1'b0;
         for (int c = 0; c < 2; c++) begin
            if (wr0_en && !(c == 0 && wr0_addr == 0)) mem_m[c][wr0_addr] = wr0_data;
            if (wr1_en && !(c == 0 && wr1_addr == 0)) mem_m[c][wr1_addr] = wr1_data;
         end
      end
   endtask

   task automatic step(input bit rst, input bit creq,
                       input bit w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                       input bit w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      @(negedge clk);
      reset = rst; clear_req = creq;
      wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
      wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
      rd_addr = {ra1, ra0};
      #1;
      obs_busy = busy_a;
      obs_drop = drop_a;
      for (int k = 0; k < NR; k++) begin
         obs_rd_a[k] = rd_data_a[k*DW +: DW];
         obs_rd_b[k] = rd_data_b[k*DW +: DW];
      end
      if (synced) begin
         check_eq("busy_a", {31'b0, busy_a}, {31'b0, sweep >= 0});
         check_eq("busy_b", {31'b0, busy_b}, {31'b0, sweep >= 0});
         check_eq("drop_a", {31'b0, drop_a}, {31'b0, drop_m});
         check_eq("drop_b", {31'b0, drop_b}, {31'b0, drop_m});
         for (int k = 0; k < NR; k++) begin
            check_eq($sformatf("rd_a%0d@%0d", k, rd_addr[k*AW +: AW]), obs_rd_a[k],
                     exp_rd(0, rd_addr[k*AW +: AW]));
            check_eq($sformatf("rd_b%0d@%0d", k, rd_addr[k*AW +: AW]), obs_rd_b[k],
                     exp_rd(1, rd_addr[k*AW +: AW]));
         end
      end
      @(posedge clk);
      model_edge();
      if (rst) synced = 1'b1;
   endtask

   task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      step(0, 0, 0, '0, '0, 0, '0, '0, ra0, ra1);
   endtask

   initial begin
      int busy_cnt;
      reset = 1'b0; clear_req = 1'b0;
      wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
      rd_addr = '0;
      for (int c = 0; c < 2; c++) for (int i = 0; i < D; i++) mem_m[c][i] = '0;

      // Reset, then count busy cycles while reading across the array
      step(1, 0, 0, '0, '0, 0, '0, '0, '0, '0);
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         idle(AW'(i % D), AW'((i + 16) % D));
         if (obs_busy) busy_cnt++;
      end
      check_eq("busy_len_reset", busy_cnt, 32);
      for (int i = 0; i < D; i += 2) idle(AW'(i), AW'(i + 1));

      // Same-address write on both ports: port 1 wins, no drop
      step(0, 0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 32'h12345678, '0, '0);
      idle(5'd5, 5'd5);
      check_eq("x5_prio", obs_rd_a[0], 32'h12345678);
      check_eq("x5_nodrop", {31'b0, obs_drop}, 32'h0);

      // Write to x0: discarded with ZERO_REG=1, stored with ZERO_REG=0
      step(0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, '0, '0, '0, '0);
      idle(5'd0, 5'd0);
      check_eq("x0_zero", obs_rd_a[0], 32'h0);
      check_eq("x0_store", obs_rd_b[0], 32'hFFFFFFFF);
      check_eq("x0_nodrop", {31'b0, obs_drop}, 32'h0);

      // Bypass vs. registered visibility
      step(0, 0, 0, '0, '0, 1, 5'd7, 32'h1, '0, '0);
      step(0, 0, 0, '0, '0, 1, 5'd7, 32'hA5A5A5A5, '0, 5'd7);
      check_eq("x7_bypass", obs_rd_b[1], 32'hA5A5A5A5);
      check_eq("x7_old", obs_rd_a[1], 32'h1);
      idle(5'd0, 5'd7);
      check_eq("x7_new", obs_rd_a[1], 32'hA5A5A5A5);

      // Clear request with coincident write, then write during the sweep
      step(0, 0, 1, 5'd3, 32'h3333, 0, '0, '0, '0, '0);
      step(0, 1, 1, 5'd3, 32'hAAAA0003, 0, '0, '0, 5'd3, 5'd7);
      step(0, 0, 1, 5'd3, 32'hBBBB0003, 0, '0, '0, 5'd3, 5'd7);
      check_eq("clr_drop1", {31'b0, obs_drop}, 32'h1);
      busy_cnt = obs_busy ? 1 : 0;
      idle(5'd3, 5'd3);
      check_eq("clr_drop2", {31'b0, obs_drop}, 32'h1);
      if (obs_busy) busy_cnt++;
      for (int i = 0; i < 38; i++) begin
         idle(5'd3, AW'(i % D));
         if (obs_busy) busy_cnt++;
      end
      check_eq("busy_len_req", busy_cnt, 32);
      check_eq("x3_cleared", obs_rd_a[0], 32'h0);

      // Reset mid-sweep restarts it; a clear_req during the sweep does not extend it
      step(0, 1, 0, '0, '0, 0, '0, '0, '0, '0);
      for (int i = 0; i < 10; i++) idle('0, '0);
      step(1, 0, 0, '0, '0, 0, '0, '0, '0, '0);
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(0, i == 5, 0, '0, '0, 0, '0, '0, AW'(i % D), 5'd7);
         if (obs_busy) busy_cnt++;
      end
      check_eq("busy_len_rst", busy_cnt, 32);

      // Randomized traffic with occasional clear requests and resets
      for (int i = 0; i < 1500; i++) begin
         bit narrow = ($urandom_range(0, 1) == 1);
         int amax   = narrow ? 7 : D - 1;
         step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 2) != 0, AW'($urandom_range(0, amax)), $urandom(),
              $urandom_range(0, 2) != 0, AW'($urandom_range(0, amax)), $urandom(),
              AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-cycle CPU register file.
- Supports configurable width, depth and number of combinational read ports, plus two synchronous write ports with fixed priority.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- A sequential clear engine wipes the array one entry per cycle after reset or on request, so the same block can later be mapped onto RAM. It sits between decode/writeback and the ALU operand muxes.

Parameters:
- DATA_WIDTH, 32, bits per entry.
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries.
- NUM_RD, 2, number of read ports (legal range 1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 0, 1 = a read of an address being written this cycle returns the new data.

Ports:
- clk, in, 1, clock, rising edge.
- reset, in, 1, reset, synchronous, active-high.
- clear_req, in, 1, single-cycle request to start a full-array clear sweep.
- wr0_en, in, 1, write port 0 enable.
- wr0_addr, in, ADDR_WIDTH, write port 0 address.
- wr0_data, in, DATA_WIDTH, write port 0 data.
- wr1_en, in, 1, write port 1 enable (higher priority).
- wr1_addr, in, ADDR_WIDTH, write port 1 address.
- wr1_data, in, DATA_WIDTH, write port 1 data.
- rd_addr, in, NUM_RD*ADDR_WIDTH, packed read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data, out, NUM_RD*DATA_WIDTH, packed read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- busy, out, 1, clear sweep in progress.
- wr_dropped, out, 1, registered pulse: at least one enabled write was discarded in the previous cycle.

Behaviour:
- States: IDLE, CLEAR. Registered clear pointer clr_ptr, ADDR_WIDTH bits.
- Reset (any edge with reset=1):
  - state<=CLEAR, clr_ptr<=0, wr_dropped<=0.
  - Array contents are not touched directly; the sweep clears them.
  - Holding reset high keeps clr_ptr at 0.
- CLEAR: each edge writes entry[clr_ptr]<=0 and increments clr_ptr; the edge with clr_ptr==DEPTH-1 sets state<=IDLE. busy is high for exactly DEPTH cycles after reset deasserts.
- IDLE with clear_req=1 at an edge: state<=CLEAR, clr_ptr<=0. The first entry is cleared on the following edge.
- clear_req while in CLEAR is ignored; the sweep does not restart. Reset during CLEAR restarts the sweep from 0.
- busy = (state==CLEAR), registered; reset value 1.
- Writes (IDLE only, clear_req=0):
  - At the edge, entry[wrN_addr]<=wrN_data for each enabled port.
  - Same address on both ports: port 1 wins, and this does not count as a drop.
  - ZERO_REG=1 and address 0: write silently discarded, not counted as a drop.
- Dropped writes: any enabled write during CLEAR, or coincident with clear_req in IDLE, is discarded and sets wr_dropped=1 on the next cycle. wr_dropped is 0 otherwise.
- Reads: combinational, zero latency, all ports independent and identical.
  - busy=1 forces every rd_data lane to 0. This includes the DEPTH cycles after reset, so rd_data reads 0 out of reset.
  - ZERO_REG=1 and rd_addr==0 returns 0.
  - BYPASS=1, IDLE, clear_req=0, and the address matches an enabled, non-discarded write: returns wr1_data if port 1 matches, else wr0_data.
  - Otherwise returns the stored entry (the old value when BYPASS=0).
- Clear and write are mutually exclusive per edge. No other arithmetic; clr_ptr wraps naturally at DEPTH-1 only on exit.

Decomposition:
- Shared header reg_file_defs.vh holds:
  - state encodings RF_IDLE=1'b0, RF_CLEAR=1'b1;
  - localparam DEPTH derivation macro;
  - read-port lane-slicing macros reused by the operand-mux block.
- Sub-module rf_clear_seq holds the IDLE/CLEAR FSM, clr_ptr, and generation of busy and clear-write strobes. The top holds the array, write arbitration, bypass muxes and wr_dropped.

Test Plan:
- Reset 1 cycle, then idle: busy high for exactly 32 cycles, rd_data all 0 throughout; busy=0 on cycle 33; every entry reads 0.
- After sweep, wr0 writes 0xDEADBEEF to x5 and wr1 writes 0x12345678 to x5 in the same cycle: next cycle rd port 0 at x5 reads 0x12345678, wr_dropped=0.
- wr0 writes 0xFFFFFFFF to x0 with ZERO_REG=1: x0 reads 0, wr_dropped=0. With ZERO_REG=0: x0 reads 0xFFFFFFFF.
- BYPASS=1, wr1 writes 0xA5A5A5A5 to x7 while rd port 1 addresses x7 (old value 0x1): same-cycle rd_data lane 1 = 0xA5A5A5A5. With BYPASS=0: 0x1, then 0xA5A5A5A5 next cycle.
- clear_req pulsed with a simultaneous wr0 to x3, then wr0 to x3 during the sweep: both writes dropped, wr_dropped=1 on each following cycle, busy for 32 cycles, x3 reads 0 afterwards.
- Reset asserted at sweep cycle 10 for 1 cycle: clr_ptr restarts at 0, busy stays high 32 more cycles; clear_req pulsed mid-sweep does not extend busy.
